// File: rtl/vx_alu_dot8_seq_pkg.sv
// Shared types and arithmetic for the sequential int8 dot-product PE.
package VX_gpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dot8_state_e;

    localparam int DOT8_PROD_W = 18;

    // Four int8 products (each exact in 16 bits) summed in 18 bits, then sign-extended.
    function automatic logic signed [31:0] dot8_lane(input logic [31:0] rs1, input logic [31:0] rs2);
        logic signed [DOT8_PROD_W-1:0] acc;
        logic signed [15:0]            a16;
        logic signed [15:0]            b16;
        logic signed [15:0]            prod;
        acc = '0;
        for (int k = 0; k < 4; k++) begin
            a16  = {{8{rs1[8*k+7]}}, rs1[8*k +: 8]};
            b16  = {{8{rs2[8*k+7]}}, rs2[8*k +: 8]};
            prod = a16 * b16;
            acc  = acc + {{(DOT8_PROD_W-16){prod[15]}}, prod};
        end
        return {{(32-DOT8_PROD_W){acc[DOT8_PROD_W-1]}}, acc};
    endfunction

endpackage

// File: rtl/vx_alu_dot8_seq_lane_group.sv
// Combinational array of DP_LANES int8 dot-product lanes; masked lanes yield zero.
module vx_dot8_lane_group #(
    parameter int DP_LANES = 1
) (
    input  logic [DP_LANES*32-1:0] rs1,
    input  logic [DP_LANES*32-1:0] rs2,
    input  logic [DP_LANES-1:0]    tmask,
    output logic [DP_LANES*32-1:0] data
);
    import VX_gpu_pkg::*;

    always_comb begin
        data = '0;
        for (int l = 0; l < DP_LANES; l++) begin
            if (tmask[l]) begin
                data[l*32 +: 32] = dot8_lane(rs1[l*32 +: 32], rs2[l*32 +: 32]);
            end
        end
    end

endmodule

// File: rtl/vx_alu_dot8_seq.sv
// Multi-cycle int8 dot-product PE iterating DP_LANES lanes per cycle.
// Optional DOT8_SKIP_INACTIVE_EN: skip lane groups with no active lanes.
module vx_alu_dot8_seq #(
    parameter int NUM_LANES = 4,
    parameter int DP_LANES  = 1,
    parameter int UUID_W    = 44,
    parameter int NW_W      = 4,
    parameter int PC_W      = 32,
    parameter int NR_W      = 5,
    parameter int PID_W     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    exe_valid,
    output logic                    exe_ready,
    input  logic [UUID_W-1:0]       exe_uuid,
    input  logic [NW_W-1:0]         exe_wid,
    input  logic [PC_W-1:0]         exe_pc,
    input  logic [NR_W-1:0]         exe_rd,
    input  logic [PID_W-1:0]        exe_pid,
    input  logic                    exe_wb,
    input  logic                    exe_sop,
    input  logic                    exe_eop,
    input  logic [NUM_LANES-1:0]    exe_tmask,
    input  logic [NUM_LANES*32-1:0] exe_rs1_data,
    input  logic [NUM_LANES*32-1:0] exe_rs2_data,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [UUID_W-1:0]       res_uuid,
    output logic [NW_W-1:0]         res_wid,
    output logic [PC_W-1:0]         res_pc,
    output logic [NR_W-1:0]         res_rd,
    output logic [PID_W-1:0]        res_pid,
    output logic                    res_wb,
    output logic                    res_sop,
    output logic                    res_eop,
    output logic [NUM_LANES-1:0]    res_tmask,
    output logic [NUM_LANES*32-1:0] res_data
);
    import VX_gpu_pkg::*;

    localparam int NUM_GROUPS = NUM_LANES / DP_LANES;
    localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int GRP_BITS   = DP_LANES * 32;

    dot8_state_e               state_q, state_d;
    logic [GRP_W-1:0]          grp_q, grp_d;
    logic [NUM_LANES*32-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, data_q, data_d;
    logic [NUM_LANES-1:0]      tmask_q, tmask_d;
    logic [UUID_W-1:0]         uuid_q, uuid_d;
    logic [NW_W-1:0]           wid_q, wid_d;
    logic [PC_W-1:0]           pc_q, pc_d;
    logic [NR_W-1:0]           rd_q, rd_d;
    logic [PID_W-1:0]          pid_q, pid_d;
    logic                      wb_q, wb_d, sop_q, sop_d, eop_q, eop_d;
    logic                      exe_ready_q, exe_ready_d, res_valid_q, res_valid_d;
    logic [GRP_BITS-1:0]       grp_rs1, grp_rs2, grp_data;
    logic [DP_LANES-1:0]       grp_tmask;

    assign grp_rs1   = rs1_q[int'(grp_q)*GRP_BITS +: GRP_BITS];
    assign grp_rs2   = rs2_q[int'(grp_q)*GRP_BITS +: GRP_BITS];
    assign grp_tmask = tmask_q[int'(grp_q)*DP_LANES +: DP_LANES];

    vx_dot8_lane_group #(
        .DP_LANES (DP_LANES)
    ) u_group (
        .rs1   (grp_rs1),
        .rs2   (grp_rs2),
        .tmask (grp_tmask),
        .data  (grp_data)
    );

`ifdef DOT8_SKIP_INACTIVE_EN
    logic [GRP_W:0] srch;

    // Lowest group index >= first holding an active lane; MSB flags a hit.
    function automatic logic [GRP_W:0] find_active(input logic [NUM_LANES-1:0] mask, input int first);
        logic [GRP_W:0] r;
        r = '0;
        for (int g = NUM_GROUPS - 1; g >= 0; g--) begin
            if (g >= first && (|mask[g*DP_LANES +: DP_LANES])) begin
                r = {1'b1, GRP_W'(g)};
            end
        end
        return r;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        data_d  = data_q;
        tmask_d = tmask_q;
        uuid_d  = uuid_q;
        wid_d   = wid_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        pid_d   = pid_q;
        wb_d    = wb_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
`ifdef DOT8_SKIP_INACTIVE_EN
        srch    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (exe_valid) begin
                    rs1_d   = exe_rs1_data;
                    rs2_d   = exe_rs2_data;
                    tmask_d = exe_tmask;
                    uuid_d  = exe_uuid;
                    wid_d   = exe_wid;
                    pc_d    = exe_pc;
                    rd_d    = exe_rd;
                    pid_d   = exe_pid;
                    wb_d    = exe_wb;
                    sop_d   = exe_sop;
                    eop_d   = exe_eop;
                    data_d  = '0;
                    grp_d   = '0;
                    state_d = BUSY;
`ifdef DOT8_SKIP_INACTIVE_EN
                    srch = find_active(exe_tmask, 0);
                    if (srch[GRP_W]) begin
                        grp_d = srch[GRP_W-1:0];
                    end else begin
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                data_d[int'(grp_q)*GRP_BITS +: GRP_BITS] = grp_data;
`ifdef DOT8_SKIP_INACTIVE_EN
                srch = find_active(tmask_q, int'(grp_q) + 1);
                if (srch[GRP_W]) begin
                    grp_d = srch[GRP_W-1:0];
                end else begin
                    state_d = DONE;
                end
`else
                if (grp_q == GRP_W'(NUM_GROUPS - 1)) begin
                    state_d = DONE;
                end else begin
                    grp_d = grp_q + GRP_W'(1);
                end
`endif
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        exe_ready_d = (state_d == IDLE);
        res_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grp_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            data_q      <= '0;
            tmask_q     <= '0;
            uuid_q      <= '0;
            wid_q       <= '0;
            pc_q        <= '0;
            rd_q        <= '0;
            pid_q       <= '0;
            wb_q        <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            exe_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            data_q      <= data_d;
            tmask_q     <= tmask_d;
            uuid_q      <= uuid_d;
            wid_q       <= wid_d;
            pc_q        <= pc_d;
            rd_q        <= rd_d;
            pid_q       <= pid_d;
            wb_q        <= wb_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            exe_ready_q <= exe_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign exe_ready = exe_ready_q;
    assign res_valid = res_valid_q;
    assign res_uuid  = uuid_q;
    assign res_wid   = wid_q;
    assign res_pc    = pc_q;
    assign res_rd    = rd_q;
    assign res_pid   = pid_q;
    assign res_wb    = wb_q;
    assign res_sop   = sop_q;
    assign res_eop   = eop_q;
    assign res_tmask = tmask_q;
    assign res_data  = data_q;

endmodule

// File: tb/tb_vx_alu_dot8_seq.sv
// Scoreboard bench for vx_alu_dot8_seq; honours DOT8_SKIP_INACTIVE_EN when predicting latency.
module tb_vx_alu_dot8_seq;

    localparam int NUM_LANES = 4;
    localparam int DP_LANES  = 1;
    localparam int TAG_W     = 44 + 4 + 32 + 5 + 1 + 3 + NUM_LANES;

    typedef struct {
        logic [TAG_W-1:0]        tags;
        logic [NUM_LANES*32-1:0] data;
        int                      hs_cyc;
        int                      lat;
    } exp_t;

    logic                    clk;
    logic                    reset;
    logic                    exe_valid, exe_ready;
    logic [43:0]             exe_uuid, res_uuid;
    logic [3:0]              exe_wid, res_wid;
    logic [31:0]             exe_pc, res_pc;
    logic [4:0]              exe_rd, res_rd;
    logic [0:0]              exe_pid, res_pid;
    logic                    exe_wb, exe_sop, exe_eop, res_wb, res_sop, res_eop;
    logic [NUM_LANES-1:0]    exe_tmask, res_tmask;
    logic [NUM_LANES*32-1:0] exe_rs1_data, exe_rs2_data, res_data;
    logic                    res_valid, res_ready;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   exe_hs_cyc = 0;
    int   res_hs_cyc = 0;
    logic prev_valid = 1'b0;

    vx_alu_dot8_seq #(
        .NUM_LANES (NUM_LANES),
        .DP_LANES  (DP_LANES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .exe_valid    (exe_valid),
        .exe_ready    (exe_ready),
        .exe_uuid     (exe_uuid),
        .exe_wid      (exe_wid),
        .exe_pc       (exe_pc),
        .exe_rd       (exe_rd),
        .exe_pid      (exe_pid),
        .exe_wb       (exe_wb),
        .exe_sop      (exe_sop),
        .exe_eop      (exe_eop),
        .exe_tmask    (exe_tmask),
        .exe_rs1_data (exe_rs1_data),
        .exe_rs2_data (exe_rs2_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_uuid     (res_uuid),
        .res_wid      (res_wid),
        .res_pc       (res_pc),
        .res_rd       (res_rd),
        .res_pid      (res_pid),
        .res_wb       (res_wb),
        .res_sop      (res_sop),
        .res_eop      (res_eop),
        .res_tmask    (res_tmask),
        .res_data     (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [TAG_W-1:0] exeTags();
        return {exe_uuid, exe_wid, exe_pc, exe_rd, exe_pid, exe_wb, exe_sop, exe_eop, exe_tmask};
    endfunction

    function automatic logic [TAG_W-1:0] resTags();
        return {res_uuid, res_wid, res_pc, res_rd, res_pid, res_wb, res_sop, res_eop, res_tmask};
    endfunction

    function automatic logic [NUM_LANES*32-1:0] modelData(input logic [NUM_LANES*32-1:0] a,
                                                          input logic [NUM_LANES*32-1:0] b,
                                                          input logic [NUM_LANES-1:0] tm);
        logic [NUM_LANES*32-1:0] r;
        byte x, y;
        int  s;
        r = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (tm[l]) begin
                s = 0;
                for (int k = 0; k < 4; k++) begin
                    x = a[l*32 + 8*k +: 8];
                    y = b[l*32 + 8*k +: 8];
                    s += int'(x) * int'(y);
                end
                r[l*32 +: 32] = s;
            end
        end
        return r;
    endfunction

    function automatic int modelLatency(input logic [NUM_LANES-1:0] tm);
        int n;
        n = 0;
        for (int g = 0; g < NUM_LANES / DP_LANES; g++) begin
`ifdef DOT8_SKIP_INACTIVE_EN
            if (|tm[g*DP_LANES +: DP_LANES]) n++;
`else
            n++;
`endif
        end
        return n + 1;
    endfunction

    // One clock: score handshakes about to happen at the next edge, then advance.
    task automatic tick();
        exp_t e;
        if (!reset) begin
            if (res_valid && !prev_valid && sb.size() > 0) begin
                checkOutput("latency", 128'(cyc - sb[0].hs_cyc), 128'(sb[0].lat));
            end
            if (res_valid && res_ready) begin
                res_hs_cyc = cyc;
                if (sb.size() == 0) begin
                    checkOutput("spurious_result", 128'(1), 128'(0));
                end else begin
                    e = sb.pop_front();
                    checkOutput("tags", 128'(resTags()), 128'(e.tags));
                    checkOutput("data", res_data, e.data);
                end
            end
            if (exe_valid && exe_ready) begin
                e.tags   = exeTags();
                e.data   = modelData(exe_rs1_data, exe_rs2_data, exe_tmask);
                e.hs_cyc = cyc;
                e.lat    = modelLatency(exe_tmask);
                sb.push_back(e);
                exe_hs_cyc = cyc;
            end
        end
        prev_valid = reset ? 1'b0 : res_valid;
        @(negedge clk);
        cyc++;
    endtask

    task automatic setFields(input logic [127:0] rs1, input logic [127:0] rs2, input logic [3:0] tm);
        exe_rs1_data = rs1;
        exe_rs2_data = rs2;
        exe_tmask    = tm;
        exe_uuid     = 44'({$urandom(), $urandom()});
        exe_wid      = 4'($urandom());
        exe_pc       = $urandom();
        exe_rd       = 5'($urandom());
        exe_pid      = 1'($urandom());
        exe_wb       = 1'($urandom());
        exe_sop      = 1'($urandom());
        exe_eop      = 1'($urandom());
    endtask

    task automatic applyStimulus(input logic [127:0] rs1, input logic [127:0] rs2,
                                 input logic [3:0] tm, input bit rnd_ready);
        bit accepted;
        accepted = 1'b0;
        setFields(rs1, rs2, tm);
        exe_valid = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            if (rnd_ready) res_ready = 1'($urandom_range(0, 1));
            accepted = exe_ready;
            tick();
        end
        exe_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 128'(0), 128'(1));
    endtask

    task automatic drain();
        res_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
        if (sb.size() != 0) checkOutput("drain_timeout", 128'(sb.size()), 128'(0));
        tick();
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        exe_valid = 1'b0;
        res_ready = 1'b0;
        setFields('0, '0, 4'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_exe_ready", 128'(exe_ready), 128'(1));
        checkOutput("rst_res_valid", 128'(res_valid), 128'(0));
        checkOutput("rst_res_data", res_data, 128'(0));
        checkOutput("rst_tags", 128'(resTags()), 128'(0));

        res_ready = 1'b1;
        applyStimulus({32'h11223344, 32'hFF00FF00, 32'h7FFF8001, 32'h01020304},
                      {32'h55667788, 32'h01FF7F80, 32'h0A0B0C0D, 32'h01010101}, 4'hF, 1'b0);
        drain();
        applyStimulus({4{32'h80808080}}, {4{32'h80808080}}, 4'hF, 1'b0);
        drain();
        applyStimulus({4{32'h7F7F7F7F}}, {4{32'h80808080}}, 4'hF, 1'b0);
        drain();
        applyStimulus({4{32'h12345678}}, {4{32'h9ABCDEF0}}, 4'b0101, 1'b0);
        drain();
        applyStimulus({4{32'hDEADBEEF}}, {4{32'h01020304}}, 4'b0000, 1'b0);
        drain();

        // Back-pressure: result held in DONE while a second request waits.
        res_ready = 1'b0;
        applyStimulus({4{32'hF1F2F3F4}}, {4{32'h05060708}}, 4'hF, 1'b0);
        for (int i = 0; i < 20 && !res_valid; i++) tick();
        checkOutput("bp_reach_done", 128'(res_valid), 128'(1));
        setFields({4{32'h0A0B0C0D}}, {4{32'hFEFDFCFB}}, 4'b1011);
        exe_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_res_valid", 128'(res_valid), 128'(1));
            checkOutput("bp_exe_ready", 128'(exe_ready), 128'(0));
            if (sb.size() > 0) checkOutput("bp_res_data", res_data, sb[0].data);
            tick();
        end
        res_ready = 1'b1;
        tick();
        for (int i = 0; i < 5 && sb.size() == 0; i++) tick();
        exe_valid = 1'b0;
        checkOutput("bp_next_accept", 128'(exe_hs_cyc - res_hs_cyc), 128'(1));
        drain();

        // Reset two cycles into BUSY drops the packet.
        applyStimulus({4{32'h01010101}}, {4{32'h02020202}}, 4'hF, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_mid_res_valid", 128'(res_valid), 128'(0));
        checkOutput("rst_mid_exe_ready", 128'(exe_ready), 128'(1));
        sb.delete();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            seen += int'(res_valid);
            tick();
        end
        checkOutput("rst_mid_no_result", 128'(seen), 128'(0));

        for (int p = 0; p < 100; p++) begin
            applyStimulus({$urandom(), $urandom(), $urandom(), $urandom()},
                          {$urandom(), $urandom(), $urandom(), $urandom()},
                          4'($urandom()), 1'b1);
        end
        drain();
        checkOutput("sb_empty", 128'(sb.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vx_alu_dot8_seq.md
# vx_alu_dot8_seq

Area-reduced, multi-cycle processing element that sits behind the ALU block's PE switch and responds to its execute/result handshake. It accepts one warp packet of packed signed int8 operands per request and computes, per lane, the 4-element int8 dot product of rs1 and rs2. It uses only DP_LANES multiplier groups, iterating over lane groups. It returns a tagged result packet on the result side with valid/ready back-pressure.

## Interface
- NUM_LANES, 4: lanes per packet (power of two).
- DP_LANES, 1: lanes computed per cycle; power of two, divides NUM_LANES.
- UUID_W, 44 / NW_W, 4 / PC_W, 32 / NR_W, 5 / PID_W, 1: tag field widths.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- exe_valid  in  1  request valid.
- exe_ready  out  1  request accepted when valid&&ready.
- exe_uuid, exe_wid, exe_pc, exe_rd, exe_pid  in  tag widths  tags, passed through unchanged.
- exe_wb, exe_sop, exe_eop  in  1 each  tags, passed through unchanged.
- exe_tmask  in  NUM_LANES  active-lane mask.
- exe_rs1_data, exe_rs2_data  in  NUM_LANES×32  packed int8 operands, byte 0 in bits [7:0].
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed when valid&&ready.
- res_uuid … res_eop, res_tmask  out  as inputs  captured tags.
- res_data  out  NUM_LANES×32  per-lane dot products.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset: state IDLE, exe_ready=1, res_valid=0, res_data=0, all tag outputs 0.
- IDLE: exe_ready=1. On handshake, capture tags, tmask and both operand arrays. Clear the group counter and go to BUSY.
- BUSY: exe_ready=0. Each cycle process lane group g (lanes g·DP_LANES … +DP_LANES-1) and write those lanes of res_data. Increment g. After the last group (NUM_LANES/DP_LANES−1), go to DONE.
- DONE: res_valid=1 and outputs are held stable. On res_ready, go to IDLE. There is no IDLE bypass: exe_ready rises the cycle after the result handshake, so there is one bubble between packets.
- Arithmetic per lane: sum over k=0..3 of sext(rs1[8k+7:8k]) × sext(rs2[8k+7:8k]).
  - Each product is 16-bit signed.
  - The sum is held in 18-bit signed.
  - Result is sign-extended to 32 bits; no saturation.
- Inactive lanes (tmask bit 0): res_data lane is 0.
- Tags, tmask, sop and eop are returned unmodified, one result per request, in order.
- res_ready asserted outside DONE has no effect. exe_valid while not in IDLE is stalled and not captured.
- reset mid-operation: return to reset values next cycle; the in-flight packet is dropped.

## Timing
- Request handshake at cycle T → res_valid at T+NUM_LANES/DP_LANES+1 (default 5).
- With DP_LANES=NUM_LANES, latency is 2.
- Throughput is one packet per latency+1 cycles, given res_ready held high.
- All outputs are registered; no combinational path from exe_* to res_*, or from res_ready to exe_ready.

## Configuration
- DOT8_SKIP_INACTIVE_EN defined:
  - In BUSY, lane groups whose captured tmask bits are all zero are skipped; the counter jumps to the next group with any active lane, computed via a priority search.
  - If tmask is all zero, go IDLE→DONE directly (latency 1).
  - Skipped groups still output 0.
- Undefined: every group is iterated; latency is fixed as above.

## Structure
- Shared package VX_gpu_pkg holds:
  - dot8_state_e (IDLE/BUSY/DONE).
  - The localparam DOT8_PROD_W=18.
  - The function dot8_lane(rs1, rs2) returning a signed 32-bit value.
- One sub-module, vx_dot8_lane_group: combinational DP_LANES×dot8_lane array. The top holds the FSM, counter and capture registers.

## Test plan
- Basic, NUM_LANES=4, DP_LANES=1, tmask=4'hF.
  - Stimulus: rs1 lane0 = 0x01020304, rs2 lane0 = 0x01010101.
  - Expected: res_data lane0 = 10, res_valid exactly 5 cycles after handshake.
- Sign extremes.
  - Stimulus: rs1 = rs2 = 0x80808080.
  - Expected: 65536 (0x00010000).
  - Stimulus: rs1 = 0x7F7F7F7F, rs2 = 0x80808080.
  - Expected: −65024 (0xFFFF0200).
- Masking: tmask=4'b0101 → lanes 1 and 3 are 0, lanes 0 and 2 are correct. With DOT8_SKIP_INACTIVE_EN and tmask=0, latency is 1 and all results are 0.
- Back-pressure.
  - Stimulus: hold res_ready=0 for 10 cycles in DONE.
  - Expected: outputs stable, exe_ready=0 throughout, exe_valid stalled; second packet accepted one cycle after the res handshake.
- Reset mid-BUSY (cycle T+2) → next cycle res_valid=0 and exe_ready=1; no result is emitted for the dropped packet.
- Tag integrity: 100 random back-to-back packets with random uuid/wid/pc/rd/sop/eop and random res_ready → all tags returned in order and match the reference model.
